axi4lite_submap_bridge: RTL

- Parametrised successor to the fixed 32-bit AXI4-lite-to-submap generator output.
- Accepts AXI4-lite transactions on a slave port and forwards them to one AXI4-lite submap master port.
- Generalised in address and data width, with an optional write-path pipeline stage.
- Propagates the submap BRESP/RRESP, which the previous generation tied to OKAY.

---
 rtl/axi4lite_pkg.sv | 14 +
 rtl/axi4lite_chan_capture.sv | 69 ++++++
 rtl/axi4lite_submap_bridge.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_pkg.sv
// Shared response codes, FSM state encodings and width helpers for the AXI4-lite submap bridge.
package axi4lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP, W_BRSP} wr_state_t;
   typedef enum logic [1:0] {R_IDLE, R_REQ, R_RESP, R_RRSP} rd_state_t;

   function automatic int unsigned strb_bits(input int unsigned dw);
      return dw / 8;
   endfunction

endpackage

// File: rtl/axi4lite_chan_capture.sv
// Captures slave AW and W beats independently and pulses a write request once both are held.
module axi4lite_chan_capture
   import axi4lite_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                             i_clk,
   input  logic                             i_rst,
   input  logic                             i_awvalid,
   input  logic [ADDR_WIDTH-1:0]            i_awaddr,
   input  logic                             i_wvalid,
   input  logic [DATA_WIDTH-1:0]            i_wdata,
   input  logic [strb_bits(DATA_WIDTH)-1:0] i_wstrb,
   input  logic                             i_clear,
   output logic                             o_awready,
   output logic                             o_wready,
   output logic                             o_req_c,
   output logic [ADDR_WIDTH-1:0]            o_addr_c,
   output logic [DATA_WIDTH-1:0]            o_data_c,
   output logic [strb_bits(DATA_WIDTH)-1:0] o_strb_c
);

   logic                             r_awready;
   logic                             r_wready;
   logic [ADDR_WIDTH-1:0]            r_awaddr;
   logic [DATA_WIDTH-1:0]            r_wdata;
   logic [strb_bits(DATA_WIDTH)-1:0] r_wstrb;
   logic                             w_aw_fire;
   logic                             w_w_fire;

   assign w_aw_fire = i_awvalid & r_awready;
   assign w_w_fire  = i_wvalid & r_wready;

   // Request fires in the cycle the second half arrives (or both together).
   assign o_req_c  = (w_aw_fire | ~r_awready) & (w_w_fire | ~r_wready) & (w_aw_fire | w_w_fire);
   assign o_addr_c = w_aw_fire ? i_awaddr : r_awaddr;
   assign o_data_c = w_w_fire ? i_wdata : r_wdata;
   assign o_strb_c = w_w_fire ? i_wstrb : r_wstrb;

   assign o_awready = r_awready;
   assign o_wready  = r_wready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_awready <= 1'b1;
         r_wready  <= 1'b1;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
      end else begin
         if (i_clear) begin
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
         end else begin
            if (w_aw_fire) begin
               r_awready <= 1'b0;
               r_awaddr  <= i_awaddr;
            end
            if (w_w_fire) begin
               r_wready <= 1'b0;
               r_wdata  <= i_wdata;
               r_wstrb  <= i_wstrb;
            end
         end
      end
   end

endmodule

// File: rtl/axi4lite_submap_bridge.sv
// AXI4-lite slave to single submap master bridge, one outstanding transaction per direction.
// Optional submap response timeout enabled by defining SUBMAP_TIMEOUT_EN.
module axi4lite_submap_bridge
   import axi4lite_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 8,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned WR_PIPE        = 1,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                             aclk,
   input  logic                             areset,
   input  logic                             s_awvalid,
   output logic                             s_awready,
   input  logic [ADDR_WIDTH-1:0]            s_awaddr,
   input  logic [2:0]                       s_awprot,
   input  logic                             s_wvalid,
   output logic                             s_wready,
   input  logic [DATA_WIDTH-1:0]            s_wdata,
   input  logic [strb_bits(DATA_WIDTH)-1:0] s_wstrb,
   output logic                             s_bvalid,
   input  logic                             s_bready,
   output logic [1:0]                       s_bresp,
   input  logic                             s_arvalid,
   output logic                             s_arready,
   input  logic [ADDR_WIDTH-1:0]            s_araddr,
   input  logic [2:0]                       s_arprot,
   output logic                             s_rvalid,
   input  logic                             s_rready,
   output logic [DATA_WIDTH-1:0]            s_rdata,
   output logic [1:0]                       s_rresp,
   output logic                             m_awvalid,
   input  logic                             m_awready,
   output logic [ADDR_WIDTH-1:0]            m_awaddr,
   output logic [2:0]                       m_awprot,
   output logic                             m_wvalid,
   input  logic                             m_wready,
   output logic [DATA_WIDTH-1:0]            m_wdata,
   output logic [strb_bits(DATA_WIDTH)-1:0] m_wstrb,
   input  logic                             m_bvalid,
   output logic                             m_bready,
   input  logic [1:0]                       m_bresp,
   output logic                             m_arvalid,
   input  logic                             m_arready,
   output logic [ADDR_WIDTH-1:0]            m_araddr,
   output logic [2:0]                       m_arprot,
   input  logic                             m_rvalid,
   output logic                             m_rready,
   input  logic [DATA_WIDTH-1:0]            m_rdata,
   input  logic [1:0]                       m_rresp
);

   localparam int unsigned SW = strb_bits(DATA_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(SW - 1);

   logic                  w_cap_req_c, w_req, w_b_done, w_wr_to, w_rd_to, w_unused;
   logic [ADDR_WIDTH-1:0] w_cap_addr_c, w_addr;
   logic [DATA_WIDTH-1:0] w_cap_data_c, w_data;
   logic [SW-1:0]         w_cap_strb_c, w_strb;

   wr_state_t             r_wr_state;
   rd_state_t             r_rd_state;
   logic                  r_m_awvalid, r_m_wvalid, r_m_bready, r_s_bvalid, r_wr_late;
   logic                  r_m_arvalid, r_m_rready, r_s_rvalid, r_s_arready, r_rd_late;
   logic [1:0]            r_s_bresp, r_s_rresp;
   logic [ADDR_WIDTH-1:0] r_m_awaddr, r_m_araddr;
   logic [DATA_WIDTH-1:0] r_m_wdata, r_s_rdata;
   logic [SW-1:0]         r_m_wstrb;

   assign w_b_done = r_s_bvalid & s_bready;

   axi4lite_chan_capture #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_capture (
      .i_clk     (aclk),
      .i_rst     (areset),
      .i_awvalid (s_awvalid),
      .i_awaddr  (s_awaddr),
      .i_wvalid  (s_wvalid),
      .i_wdata   (s_wdata),
      .i_wstrb   (s_wstrb),
      .i_clear   (w_b_done),
      .o_awready (s_awready),
      .o_wready  (s_wready),
      .o_req_c   (w_cap_req_c),
      .o_addr_c  (w_cap_addr_c),
      .o_data_c  (w_cap_data_c),
      .o_strb_c  (w_cap_strb_c)
   );

   if (WR_PIPE != 0) begin : g_wr_pipe
      logic                  r_req;
      logic [ADDR_WIDTH-1:0] r_addr;
      logic [DATA_WIDTH-1:0] r_data;
      logic [SW-1:0]         r_strb;
      always_ff @(posedge aclk) begin
         if (areset) begin
            r_req  <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_strb <= '0;
         end else begin
            r_req  <= w_cap_req_c;
            r_addr <= w_cap_addr_c;
            r_data <= w_cap_data_c;
            r_strb <= w_cap_strb_c;
         end
      end
      assign w_req  = r_req;
      assign w_addr = r_addr;
      assign w_data = r_data;
      assign w_strb = r_strb;
   end else begin : g_wr_direct
      assign w_req  = w_cap_req_c;
      assign w_addr = w_cap_addr_c;
      assign w_data = w_cap_data_c;
      assign w_strb = w_cap_strb_c;
   end

`ifdef SUBMAP_TIMEOUT_EN
   logic [15:0] r_wr_cnt, r_rd_cnt;

   // Counters run from zero on entry to the request state until a response state is reached.
   always_ff @(posedge aclk) begin
      if (areset || r_wr_state == W_IDLE || r_wr_state == W_BRSP) r_wr_cnt <= '0;
      else                                                        r_wr_cnt <= r_wr_cnt + 16'd1;
      if (areset || r_rd_state == R_IDLE || r_rd_state == R_RRSP) r_rd_cnt <= '0;
      else                                                        r_rd_cnt <= r_rd_cnt + 16'd1;
   end

   assign w_wr_to  = (r_wr_state == W_REQ || r_wr_state == W_RESP) && (r_wr_cnt == 16'(TIMEOUT_CYCLES - 1));
   assign w_rd_to  = (r_rd_state == R_REQ || r_rd_state == R_RESP) && (r_rd_cnt == 16'(TIMEOUT_CYCLES - 1));
   assign w_unused = ^{s_awprot, s_arprot};
`else
   assign w_wr_to  = 1'b0;
   assign w_rd_to  = 1'b0;
   assign w_unused = ^{s_awprot, s_arprot, 32'(TIMEOUT_CYCLES)};
`endif

   // Write path: issue AW/W to the submap, wait for B, return it on the slave port.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_wr_state  <= W_IDLE;
         r_m_awvalid <= 1'b0;
         r_m_wvalid  <= 1'b0;
         r_m_awaddr  <= '0;
         r_m_wdata   <= '0;
         r_m_wstrb   <= '0;
         r_m_bready  <= 1'b0;
         r_s_bvalid  <= 1'b0;
         r_s_bresp   <= RESP_OKAY;
         r_wr_late   <= 1'b0;
      end else begin
         case (r_wr_state)
            W_IDLE: begin
               r_m_bready <= 1'b0;
               if (w_req) begin
                  r_wr_state  <= W_REQ;
                  r_m_awvalid <= 1'b1;
                  r_m_wvalid  <= 1'b1;
                  r_m_awaddr  <= w_addr & ADDR_MASK;
                  r_m_wdata   <= w_data;
                  r_m_wstrb   <= w_strb;
               end
            end
            W_REQ: begin
               if (w_wr_to) begin
                  r_m_awvalid <= 1'b0;
                  r_m_wvalid  <= 1'b0;
                  r_s_bvalid  <= 1'b1;
                  r_s_bresp   <= RESP_SLVERR;
                  r_wr_late   <= 1'b1;
                  r_wr_state  <= W_BRSP;
               end else begin
                  if (m_awready) r_m_awvalid <= 1'b0;
                  if (m_wready)  r_m_wvalid  <= 1'b0;
                  if ((!r_m_awvalid || m_awready) && (!r_m_wvalid || m_wready)) begin
                     r_m_bready <= 1'b1;
                     r_wr_state <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (m_bvalid || w_wr_to) begin
                  r_m_bready <= 1'b0;
                  r_s_bvalid <= 1'b1;
                  r_s_bresp  <= m_bvalid ? m_bresp : RESP_SLVERR;
                  r_wr_late  <= !m_bvalid;
                  r_wr_state <= W_BRSP;
               end
            end
            W_BRSP: begin
               if (s_bready) begin
                  r_s_bvalid <= 1'b0;
                  r_m_bready <= r_wr_late;
                  r_wr_late  <= 1'b0;
                  r_wr_state <= W_IDLE;
               end
            end
            default: r_wr_state <= W_IDLE;
         endcase
      end
   end

   // Read path: issue AR, wait for R, hold data on the slave port until accepted.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_rd_state  <= R_IDLE;
         r_s_arready <= 1'b1;
         r_m_arvalid <= 1'b0;
         r_m_araddr  <= '0;
         r_m_rready  <= 1'b0;
         r_s_rvalid  <= 1'b0;
         r_s_rdata   <= '0;
         r_s_rresp   <= RESP_OKAY;
         r_rd_late   <= 1'b0;
      end else begin
         case (r_rd_state)
            R_IDLE: begin
               r_m_rready <= 1'b0;
               if (s_arvalid && r_s_arready) begin
                  r_s_arready <= 1'b0;
                  r_m_arvalid <= 1'b1;
                  r_m_araddr  <= s_araddr & ADDR_MASK;
                  r_rd_state  <= R_REQ;
               end
            end
            R_REQ: begin
               if (w_rd_to) begin
                  r_m_arvalid <= 1'b0;
                  r_s_rvalid  <= 1'b1;
                  r_s_rdata   <= '0;
                  r_s_rresp   <= RESP_SLVERR;
                  r_rd_late   <= 1'b1;
                  r_rd_state  <= R_RRSP;
               end else if (m_arready) begin
                  r_m_arvalid <= 1'b0;
                  r_m_rready  <= 1'b1;
                  r_rd_state  <= R_RESP;
               end
            end
            R_RESP: begin
               if (m_rvalid || w_rd_to) begin
                  r_m_rready <= 1'b0;
                  r_s_rvalid <= 1'b1;
                  r_s_rdata  <= m_rvalid ? m_rdata : '0;
                  r_s_rresp  <= m_rvalid ? m_rresp : RESP_SLVERR;
                  r_rd_late  <= !m_rvalid;
                  r_rd_state <= R_RRSP;
               end
            end
            R_RRSP: begin
               if (s_rready) begin
                  r_s_rvalid  <= 1'b0;
                  r_s_arready <= 1'b1;
                  r_m_rready  <= r_rd_late;
                  r_rd_late   <= 1'b0;
                  r_rd_state  <= R_IDLE;
               end
            end
            default: r_rd_state <= R_IDLE;
         endcase
      end
   end

   assign m_awvalid = r_m_awvalid;
   assign m_awaddr  = r_m_awaddr;
   assign m_awprot  = 3'b000;
   assign m_wvalid  = r_m_wvalid;
   assign m_wdata   = r_m_wdata;
   assign m_wstrb   = r_m_wstrb;
   assign m_bready  = r_m_bready;
   assign s_bvalid  = r_s_bvalid;
   assign s_bresp   = r_s_bresp;
   assign s_arready = r_s_arready;
   assign m_arvalid = r_m_arvalid;
   assign m_araddr  = r_m_araddr;
   assign m_arprot  = 3'b000;
   assign m_rready  = r_m_rready;
   assign s_rvalid  = r_s_rvalid;
   assign s_rdata   = r_s_rdata;
   assign s_rresp   = r_s_rresp;

endmodule
